// File: rtl/matmul_pkg.sv
// matmul_pkg: shared matmul sizes, result-checker FSM state type and SP element addressing helper
package matmul_pkg;
    localparam int BUS_WIDTH = 8;
    localparam int MAX_DIM   = 4;
    typedef enum logic [1:0] {CHK_IDLE, CHK_CHECK, CHK_DONE} chk_state_t;
    // Bit offset of element (r,c) in the flattened row-major SP C image.
    function automatic int sp_elem_lsb(input int r, input int c, input int dim = MAX_DIM, input int width = BUS_WIDTH);
        return (r * dim + c) * width;
    endfunction
endpackage

// File: rtl/matmul_chk_cmp.sv
// matmul_chk_cmp: combinational got-vs-exp compare with sign/zero extension and absolute tolerance
// Ports: got, exp (W bits each), is_signed (1 = signed compare), mismatch (|got-exp| > TOL).
module matmul_chk_cmp #(
    parameter int W   = 8,
    parameter int TOL = 0
) (
    input  logic [W-1:0] got,
    input  logic [W-1:0] exp,
    input  logic         is_signed,
    output logic         mismatch
);
    logic [W:0]   gx, ex;
    logic [W+1:0] diff, mag;
    always_comb begin
        gx       = {is_signed & got[W-1], got};
        ex       = {is_signed & exp[W-1], exp};
        diff     = {gx[W], gx} - {ex[W], ex};
        mag      = diff[W+1] ? -diff : diff;
        mismatch = mag > (W+2)'(TOL);
    end
endmodule

// File: rtl/matmul_result_checker.sv
// matmul_result_checker: streams expected C elements against the scratchpad C image and records test results
// Ports: clk_i/rst_i (sync, active-high); start_i, rows_i, cols_i, signed_i, flags_i configure a test;
// data_sp_i is the row-major SP C image; exp_valid_i/exp_data_i/exp_ready_o carry the expected stream;
// busy_o, done_o, cfg_err_o, error_cnt_o, test_num_o, first_err_*, flags_o report status and results.
module matmul_result_checker #(
    parameter int BUS_WIDTH = matmul_pkg::BUS_WIDTH,
    parameter int MAX_DIM   = matmul_pkg::MAX_DIM,
    parameter int ABS_TOL   = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [$clog2(MAX_DIM):0]           rows_i,
    input  logic [$clog2(MAX_DIM):0]           cols_i,
    input  logic                               signed_i,
    input  logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0] data_sp_i,
    input  logic [BUS_WIDTH-1:0]               flags_i,
    input  logic                               exp_valid_i,
    input  logic [BUS_WIDTH-1:0]               exp_data_i,
    output logic                               exp_ready_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               cfg_err_o,
    output logic [CNT_WIDTH-1:0]               error_cnt_o,
    output logic [CNT_WIDTH-1:0]               test_num_o,
    output logic                               first_err_vld_o,
    output logic [$clog2(MAX_DIM)-1:0]         first_err_row_o,
    output logic [$clog2(MAX_DIM)-1:0]         first_err_col_o,
    output logic [BUS_WIDTH-1:0]               first_err_exp_o,
    output logic [BUS_WIDTH-1:0]               first_err_got_o,
    output logic [BUS_WIDTH-1:0]               flags_o
);
    import matmul_pkg::*;
    localparam int IW = $clog2(MAX_DIM);
    localparam int DW = IW + 1;
    localparam logic [DW-1:0] MAXD = DW'(MAX_DIM);
    chk_state_t           state;
    logic [DW-1:0]        rows_q, cols_q;
    logic [IW-1:0]        r, c;
    logic                 sgn_q, mismatch, accept, last, col_end;
    logic [BUS_WIDTH-1:0] got;
    logic [BUS_WIDTH-1:0] elem [MAX_DIM][MAX_DIM];
    for (genvar g = 0; g < MAX_DIM; g++) begin : g_row
        for (genvar h = 0; h < MAX_DIM; h++) begin : g_col
            assign elem[g][h] = data_sp_i[sp_elem_lsb(g, h, MAX_DIM, BUS_WIDTH) +: BUS_WIDTH];
        end
    end
    assign got         = elem[r][c];
    assign exp_ready_o = state == CHK_CHECK;
    assign busy_o      = state != CHK_IDLE;
    assign done_o      = state == CHK_DONE;
    assign accept      = exp_ready_o && exp_valid_i;
    assign col_end     = DW'(c) == cols_q - DW'(1);
    assign last        = col_end && DW'(r) == rows_q - DW'(1);
    matmul_chk_cmp #(.W(BUS_WIDTH), .TOL(ABS_TOL)) u_cmp (
        .got      (got),
        .exp      (exp_data_i),
        .is_signed(sgn_q),
        .mismatch (mismatch)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= CHK_IDLE;
            rows_q          <= '0;
            cols_q          <= '0;
            r               <= '0;
            c               <= '0;
            sgn_q           <= 1'b0;
            cfg_err_o       <= 1'b0;
            error_cnt_o     <= '0;
            test_num_o      <= '0;
            first_err_vld_o <= 1'b0;
            first_err_row_o <= '0;
            first_err_col_o <= '0;
            first_err_exp_o <= '0;
            first_err_got_o <= '0;
            flags_o         <= '0;
        end else begin
            case (state)
                CHK_IDLE: if (start_i) begin
                    rows_q          <= rows_i > MAXD ? MAXD : rows_i;
                    cols_q          <= cols_i > MAXD ? MAXD : cols_i;
                    cfg_err_o       <= rows_i > MAXD || cols_i > MAXD;
                    sgn_q           <= signed_i;
                    flags_o         <= flags_i;
                    error_cnt_o     <= '0;
                    first_err_vld_o <= 1'b0;
                    first_err_row_o <= '0;
                    first_err_col_o <= '0;
                    first_err_exp_o <= '0;
                    first_err_got_o <= '0;
                    r               <= '0;
                    c               <= '0;
                    state           <= (rows_i == '0 || cols_i == '0) ? CHK_DONE : CHK_CHECK;
                end
                CHK_CHECK: if (accept) begin
                    if (mismatch) begin
                        if (~&error_cnt_o) error_cnt_o <= error_cnt_o + CNT_WIDTH'(1);
                        if (!first_err_vld_o) begin
                            first_err_vld_o <= 1'b1;
                            first_err_row_o <= r;
                            first_err_col_o <= c;
                            first_err_exp_o <= exp_data_i;
                            first_err_got_o <= got;
                        end
                    end
                    if (last) state <= CHK_DONE;
                    else if (col_end) begin
                        c <= '0;
                        r <= r + IW'(1);
                    end else c <= c + IW'(1);
                end
                CHK_DONE: begin
                    test_num_o <= test_num_o + CNT_WIDTH'(1);
                    state      <= CHK_IDLE;
                end
                default: state <= CHK_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_result_checker.sv
// tb_matmul_result_checker: directed scoreboard bench for matmul_result_checker (exact and tolerance-1 instances)
module tb_matmul_result_checker;
    localparam int BW = 8;
    localparam int MD = 4;
    typedef struct {
        int         cnt0;
        int         cnt1;
        bit         vld;
        int         row;
        int         col;
        logic [7:0] e;
        logic [7:0] g;
        bit         cfg;
        int         n;
        int         done_cyc;
        logic [7:0] flags;
    } exp_t;
    logic            clk = 0, rst_i = 1, start_i = 0, signed_i = 0, exp_valid_i = 0;
    logic [2:0]      rows_i = 0, cols_i = 0;
    logic [BW*MD*MD-1:0] data_sp_i = '0;
    logic [BW-1:0]   flags_i = 0, exp_data_i = 0;
    logic            exp_ready_o, busy_o, done_o, cfg_err_o, first_err_vld_o;
    logic [15:0]     error_cnt_o, test_num_o;
    logic [1:0]      first_err_row_o, first_err_col_o;
    logic [BW-1:0]   first_err_exp_o, first_err_got_o, flags_o;
    logic            t_ready, t_busy, t_done, t_cfg, t_vld;
    logic [15:0]     t_cnt, t_num;
    logic [1:0]      t_row, t_col;
    logic [BW-1:0]   t_exp, t_got, t_flags;
    logic [7:0]      sp [MD][MD];
    logic [7:0]      ex [MD][MD];
    exp_t            sb [$];
    int              checks = 0, failures = 0, tnum = 0;
    always #5 clk = ~clk;
    matmul_result_checker #(.BUS_WIDTH(BW), .MAX_DIM(MD), .ABS_TOL(0)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .rows_i(rows_i), .cols_i(cols_i),
        .signed_i(signed_i), .data_sp_i(data_sp_i), .flags_i(flags_i), .exp_valid_i(exp_valid_i),
        .exp_data_i(exp_data_i), .exp_ready_o(exp_ready_o), .busy_o(busy_o), .done_o(done_o),
        .cfg_err_o(cfg_err_o), .error_cnt_o(error_cnt_o), .test_num_o(test_num_o),
        .first_err_vld_o(first_err_vld_o), .first_err_row_o(first_err_row_o),
        .first_err_col_o(first_err_col_o), .first_err_exp_o(first_err_exp_o),
        .first_err_got_o(first_err_got_o), .flags_o(flags_o)
    );
    matmul_result_checker #(.BUS_WIDTH(BW), .MAX_DIM(MD), .ABS_TOL(1)) dut_tol (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .rows_i(rows_i), .cols_i(cols_i),
        .signed_i(signed_i), .data_sp_i(data_sp_i), .flags_i(flags_i), .exp_valid_i(exp_valid_i),
        .exp_data_i(exp_data_i), .exp_ready_o(t_ready), .busy_o(t_busy), .done_o(t_done),
        .cfg_err_o(t_cfg), .error_cnt_o(t_cnt), .test_num_o(t_num),
        .first_err_vld_o(t_vld), .first_err_row_o(t_row), .first_err_col_o(t_col),
        .first_err_exp_o(t_exp), .first_err_got_o(t_got), .flags_o(t_flags)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask
    function automatic bit mism(input logic [7:0] g, input logic [7:0] e, input bit sg, input int tol);
        int gv, ev, d;
        gv = sg ? int'($signed(g)) : int'(g);
        ev = sg ? int'($signed(e)) : int'(e);
        d  = gv - ev;
        if (d < 0) d = -d;
        return d > tol;
    endfunction
    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < MD; i++)
            for (int j = 0; j < MD; j++) begin
                sp[i][j] = v;
                ex[i][j] = v;
            end
    endtask
    task automatic pack();
        for (int i = 0; i < MD; i++)
            for (int j = 0; j < MD; j++)
                data_sp_i[(i*MD+j)*BW +: BW] = sp[i][j];
    endtask
    task automatic run_test(input string name, input int nr, input int nc, input bit sg,
                            input bit gap, input bit poke, input logic [7:0] fl);
        exp_t e;
        int er, ec, k, cyc;
        er = nr > MD ? MD : nr;
        ec = nc > MD ? MD : nc;
        e = '{default: 0};
        e.n = er * ec;
        e.cfg = nr > MD || nc > MD;
        e.flags = fl;
        for (int i = 0; i < e.n; i++) begin
            if (mism(sp[i/ec][i%ec], ex[i/ec][i%ec], sg, 0)) begin
                if (!e.vld) begin
                    e.vld = 1;
                    e.row = i / ec;
                    e.col = i % ec;
                    e.e = ex[i/ec][i%ec];
                    e.g = sp[i/ec][i%ec];
                end
                e.cnt0++;
            end
            if (mism(sp[i/ec][i%ec], ex[i/ec][i%ec], sg, 1)) e.cnt1++;
        end
        e.done_cyc = e.n == 0 ? 1 : gap ? 2 * e.n : e.n + 1;
        sb.push_back(e);
        pack();
        @(posedge clk); #1;
        start_i = 1; rows_i = 3'(nr); cols_i = 3'(nc); signed_i = sg; flags_i = fl; exp_valid_i = 0;
        @(posedge clk); #1;
        start_i = 0; flags_i = ~fl;
        cyc = 1; k = 0;
        while (!done_o && cyc < 100) begin
            if (poke && cyc == 2) begin
                start_i = 1; rows_i = 1; cols_i = 1; signed_i = !sg;
            end else begin
                start_i = 0; rows_i = 3'(nr); cols_i = 3'(nc); signed_i = sg;
            end
            exp_valid_i = !gap || cyc % 2 == 1;
            exp_data_i = 0;
            if (k < e.n) exp_data_i = ex[k/ec][k%ec];
            if (exp_valid_i && exp_ready_o) k++;
            @(posedge clk); #1;
            cyc++;
        end
        exp_valid_i = 0; start_i = 0;
        e = sb.pop_front();
        chk({name, "_done_seen"}, 32'(done_o), 1);
        chk({name, "_done_cycle"}, cyc, e.done_cyc);
        chk({name, "_accepts"}, k, e.n);
        chk({name, "_busy_in_done"}, 32'(busy_o), 1);
        chk({name, "_err_cnt"}, error_cnt_o, e.cnt0);
        chk({name, "_err_cnt_tol1"}, t_cnt, e.cnt1);
        chk({name, "_first_vld"}, 32'(first_err_vld_o), 32'(e.vld));
        chk({name, "_cfg_err"}, 32'(cfg_err_o), 32'(e.cfg));
        chk({name, "_flags"}, flags_o, e.flags);
        if (e.vld) begin
            chk({name, "_first_row"}, first_err_row_o, e.row);
            chk({name, "_first_col"}, first_err_col_o, e.col);
            chk({name, "_first_exp"}, first_err_exp_o, e.e);
            chk({name, "_first_got"}, first_err_got_o, e.g);
        end
        @(posedge clk); #1;
        tnum++;
        chk({name, "_done_pulse"}, 32'(done_o), 0);
        chk({name, "_idle_after"}, 32'(busy_o), 0);
        chk({name, "_test_num"}, test_num_o, tnum);
        chk({name, "_err_held"}, error_cnt_o, e.cnt0);
    endtask
    initial begin
        int dn;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_ready", 32'(exp_ready_o), 0);
        chk("rst_err_cnt", error_cnt_o, 0);
        chk("rst_test_num", test_num_o, 0);
        chk("rst_flags", flags_o, 0);
        rst_i = 0;
        // reset in the middle of a test, after one mismatching element
        fill(8'd1);
        ex[0][0] = 8'd2;
        pack();
        @(posedge clk); #1;
        start_i = 1; rows_i = 2; cols_i = 2; signed_i = 0; flags_i = 8'h5A;
        @(posedge clk); #1;
        start_i = 0; exp_valid_i = 1; exp_data_i = ex[0][0];
        chk("mid_ready", 32'(exp_ready_o), 1);
        @(posedge clk); #1;
        chk("mid_err_live", error_cnt_o, 1);
        chk("mid_flags_live", flags_o, 8'h5A);
        exp_data_i = ex[0][1]; rst_i = 1;
        @(posedge clk); #1;
        rst_i = 0; exp_valid_i = 0;
        chk("mid_rst_busy", 32'(busy_o), 0);
        chk("mid_rst_done", 32'(done_o), 0);
        chk("mid_rst_err_cnt", error_cnt_o, 0);
        chk("mid_rst_first_vld", 32'(first_err_vld_o), 0);
        chk("mid_rst_flags", flags_o, 0);
        chk("mid_rst_test_num", test_num_o, 0);
        dn = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done_o) dn++;
        end
        chk("mid_rst_no_done", dn, 0);
        // 2x2 unsigned exact match
        fill(8'd0);
        sp[0][0] = 1; sp[0][1] = 2; sp[1][0] = 3; sp[1][1] = 4;
        ex[0][0] = 1; ex[0][1] = 2; ex[1][0] = 3; ex[1][1] = 4;
        run_test("u2x2", 2, 2, 0, 0, 0, 8'h11);
        // 3x2 signed with two mismatches, stray start while checking
        fill(8'd0);
        sp[0][0] = 10; sp[0][1] = 20; sp[1][0] = 30; sp[1][1] = 8'hFB; sp[2][0] = 8; sp[2][1] = 7;
        ex[0][0] = 10; ex[0][1] = 20; ex[1][0] = 30; ex[1][1] = 8'hFC; ex[2][0] = 9; ex[2][1] = 7;
        run_test("s3x2", 3, 2, 1, 0, 1, 8'h22);
        // unsigned 0xFF vs 0x7F
        fill(8'd0);
        sp[0][0] = 8'hFF; ex[0][0] = 8'h7F;
        run_test("uff", 1, 1, 0, 0, 0, 8'h33);
        // empty test
        run_test("rows0", 0, 2, 0, 0, 0, 8'h44);
        // oversize rows clamp to MAX_DIM
        fill(8'd0);
        for (int i = 0; i < MD; i++)
            for (int j = 0; j < 2; j++) begin
                sp[i][j] = 8'(i * 16 + j + 3);
                ex[i][j] = 8'(i * 16 + j + 3);
            end
        ex[3][1] = 8'h80;
        run_test("clamp", MD + 1, 2, 0, 0, 0, 8'h55);
        // expected stream valid every other cycle
        fill(8'd0);
        sp[0][0] = 5; sp[0][1] = 6; sp[1][0] = 7; sp[1][1] = 8;
        ex[0][0] = 5; ex[0][1] = 6; ex[1][0] = 7; ex[1][1] = 9;
        run_test("gap", 2, 2, 0, 1, 0, 8'h66);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
